// File: rtl/cndm_proto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cndm_proto_pkg
// Description : Shared AXI response codes and FSM state type for the
//               cndm_proto command-driven AXI-lite master.
// Revision    : 1.0 - initial release
// ============================================================================
package cndm_proto_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/taxi_axil_if.sv
`default_nettype none
// ============================================================================
// Module      : taxi_axil_if
// Description : AXI4-lite bundle with write/read master and slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W/8,
    parameter int USER_W = 1
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic [USER_W-1:0] awuser;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [USER_W-1:0] wuser;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic [USER_W-1:0] buser;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic [USER_W-1:0] aruser;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [USER_W-1:0] ruser;
    logic              rvalid;
    logic              rready;

    modport wr_mst (
        output awaddr, awprot, awuser, awvalid, input awready,
        output wdata, wstrb, wuser, wvalid, input wready,
        input bresp, buser, bvalid, output bready
    );
    modport rd_mst (
        output araddr, arprot, aruser, arvalid, input arready,
        input rdata, rresp, ruser, rvalid, output rready
    );
    modport wr_slv (
        input awaddr, awprot, awuser, awvalid, output awready,
        input wdata, wstrb, wuser, wvalid, output wready,
        output bresp, buser, bvalid, input bready
    );
    modport rd_slv (
        input araddr, arprot, aruser, arvalid, output arready,
        output rdata, rresp, ruser, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/cndm_proto_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : cndm_proto_axil_cmd_master
// Description : Converts a valid/ready command stream into single AXI-lite
//               transactions and returns result plus bus latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cndm_proto_axil_cmd_master
    import cndm_proto_pkg::*;
#(
    parameter int TAG_W  = 8,
    parameter int CYC_W  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W/8
) (
    input  logic              clk,
    input  logic              rst,
    taxi_axil_if.wr_mst       m_axil_wr,
    taxi_axil_if.rd_mst       m_axil_rd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [CYC_W-1:0]  rsp_cycles
);

    localparam logic [CYC_W-1:0] c_cnt_max = '1;
    localparam logic [CYC_W-1:0] c_cnt_one = CYC_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [STRB_W-1:0] r_strb;
    logic [TAG_W-1:0]  r_tag;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_arvalid;
    logic [CYC_W-1:0]  r_cnt;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_resp;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [CYC_W-1:0]  r_rsp_cycles;

    logic             w_cmd_fire;
    logic             w_aw_fire;
    logic             w_w_fire;
    logic             w_b_fire;
    logic             w_ar_fire;
    logic             w_r_fire;
    logic             w_busy;
    logic [CYC_W-1:0] w_cnt_inc;

    assign cmd_ready  = (r_state == IDLE) && !rst;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_aw_fire  = r_awvalid && m_axil_wr.awready;
    assign w_w_fire   = r_wvalid && m_axil_wr.wready;
    assign w_b_fire   = (r_state == WR_RESP) && m_axil_wr.bvalid;
    assign w_ar_fire  = r_arvalid && m_axil_rd.arready;
    assign w_r_fire   = (r_state == RD_DATA) && m_axil_rd.rvalid;
    assign w_busy     = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                        (r_state == RD_REQ) || (r_state == RD_DATA);
    // Latency includes the B/R handshake cycle, so the captured value is one past the counter.
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    assign m_axil_wr.awaddr  = r_addr;
    assign m_axil_wr.awprot  = 3'b000;
    assign m_axil_wr.awuser  = '0;
    assign m_axil_wr.awvalid = r_awvalid;
    assign m_axil_wr.wdata   = r_data;
    assign m_axil_wr.wstrb   = r_strb;
    assign m_axil_wr.wuser   = '0;
    assign m_axil_wr.wvalid  = r_wvalid;
    assign m_axil_wr.bready  = (r_state == WR_RESP);
    assign m_axil_rd.araddr  = r_addr;
    assign m_axil_rd.arprot  = 3'b000;
    assign m_axil_rd.aruser  = '0;
    assign m_axil_rd.arvalid = r_arvalid;
    assign m_axil_rd.rready  = (r_state == RD_DATA);

    assign rsp_valid  = (r_state == RSP);
    assign rsp_write  = r_rsp_write;
    assign rsp_data   = r_rsp_data;
    assign rsp_resp   = r_rsp_resp;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_cycles = r_rsp_cycles;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_state_next = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if ((!r_awvalid || w_aw_fire) && (!r_wvalid || w_w_fire)) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: if (w_b_fire)  w_state_next = RSP;
            RD_REQ:  if (w_ar_fire) w_state_next = RD_DATA;
            RD_DATA: if (w_r_fire)  w_state_next = RSP;
            RSP:     if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_strb       <= '0;
            r_tag        <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_cnt        <= '0;
            r_rsp_write  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_resp   <= RESP_OKAY;
            r_rsp_tag    <= '0;
            r_rsp_cycles <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_fire) begin
                r_write   <= cmd_write;
                r_addr    <= cmd_addr;
                r_data    <= cmd_data;
                r_strb    <= cmd_strb;
                r_tag     <= cmd_tag;
                r_awvalid <= cmd_write;
                r_wvalid  <= cmd_write;
                r_arvalid <= !cmd_write;
                r_cnt     <= '0;
            end
            if (w_aw_fire) r_awvalid <= 1'b0;
            if (w_w_fire)  r_wvalid  <= 1'b0;
            if (w_ar_fire) r_arvalid <= 1'b0;
            if (w_busy)    r_cnt     <= w_cnt_inc;
            if (w_b_fire) begin
                r_rsp_write  <= r_write;
                r_rsp_data   <= '0;
                r_rsp_resp   <= m_axil_wr.bresp;
                r_rsp_tag    <= r_tag;
                r_rsp_cycles <= w_cnt_inc;
            end
            if (w_r_fire) begin
                r_rsp_write  <= r_write;
                r_rsp_data   <= m_axil_rd.rdata;
                r_rsp_resp   <= m_axil_rd.rresp;
                r_rsp_tag    <= r_tag;
                r_rsp_cycles <= w_cnt_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cndm_proto_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cndm_proto_axil_cmd_master
// Description : Directed bench for the AXI-lite command master, with a
//               configurable-latency slave and a small CYC_W=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cndm_proto_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Main instance (CYC_W=16)
    taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_strb;
    logic [7:0]  cmd_tag;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_tag;
    logic [15:0] rsp_cycles;

    cndm_proto_axil_cmd_master #(.TAG_W(8), .CYC_W(16)) dut (
        .clk(clk), .rst(rst), .m_axil_wr(axil), .m_axil_rd(axil),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_tag(rsp_tag), .rsp_cycles(rsp_cycles)
    );

    // Saturation instance (CYC_W=4)
    taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil2 ();
    logic        cmd_valid2, cmd_ready2, cmd_write2;
    logic [31:0] cmd_addr2, cmd_data2;
    logic [3:0]  cmd_strb2;
    logic [7:0]  cmd_tag2;
    logic        rsp_valid2, rsp_ready2, rsp_write2;
    logic [31:0] rsp_data2;
    logic [1:0]  rsp_resp2;
    logic [7:0]  rsp_tag2;
    logic [3:0]  rsp_cycles2;

    cndm_proto_axil_cmd_master #(.TAG_W(8), .CYC_W(4)) dut2 (
        .clk(clk), .rst(rst), .m_axil_wr(axil2), .m_axil_rd(axil2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write2),
        .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .cmd_strb(cmd_strb2), .cmd_tag(cmd_tag2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_write(rsp_write2),
        .rsp_data(rsp_data2), .rsp_resp(rsp_resp2), .rsp_tag(rsp_tag2), .rsp_cycles(rsp_cycles2)
    );

    // Slave knobs and handshake bookkeeping for the main instance
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rd_val = 32'h0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          b_started = 0, r_started = 0;
    logic [31:0] last_awaddr, last_wdata, last_araddr;
    logic [3:0]  last_wstrb;
    logic [2:0]  last_awprot, last_arprot;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: samples pre-edge values at the active edge
    initial forever begin
        @(posedge clk);
        if (axil.awvalid && axil.awready) begin
            aw_hs++; last_awaddr = axil.awaddr; last_awprot = axil.awprot;
        end
        if (axil.wvalid && axil.wready) begin
            w_hs++; last_wdata = axil.wdata; last_wstrb = axil.wstrb;
        end
        if (axil.bvalid && axil.bready) b_hs++;
        if (axil.arvalid && axil.arready) begin
            ar_hs++; last_araddr = axil.araddr; last_arprot = axil.arprot;
        end
        if (axil.rvalid && axil.rready) r_hs++;
    end

    // Slave model: drives its outputs on the falling edge
    initial begin
        int aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = 0, r_cnt = 0;
        axil.awready = 0; axil.wready = 0; axil.arready = 0;
        axil.bvalid = 0; axil.bresp = 0; axil.buser = 0;
        axil.rvalid = 0; axil.rresp = 0; axil.rdata = 0; axil.ruser = 0;
        forever begin
            @(negedge clk);
            if (axil.awvalid) begin axil.awready = (aw_seen >= aw_wait); aw_seen++; end
            else begin axil.awready = 0; aw_seen = 0; end
            if (axil.wvalid) begin axil.wready = (w_seen >= w_wait); w_seen++; end
            else begin axil.wready = 0; w_seen = 0; end
            if (axil.arvalid) begin axil.arready = (ar_seen >= ar_wait); ar_seen++; end
            else begin axil.arready = 0; ar_seen = 0; end
            if (axil.bvalid && b_hs == b_started) axil.bvalid = 0;
            if (!axil.bvalid && aw_hs > b_started && w_hs > b_started) begin
                if (b_cnt >= b_wait) begin
                    axil.bvalid = 1; axil.bresp = bresp_val; b_started++; b_cnt = 0;
                end else b_cnt++;
            end
            if (axil.rvalid && r_hs == r_started) axil.rvalid = 0;
            if (!axil.rvalid && ar_hs > r_started) begin
                if (r_cnt >= r_wait) begin
                    axil.rvalid = 1; axil.rdata = rd_val; axil.rresp = rresp_val; r_started++; r_cnt = 0;
                end else r_cnt++;
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [7:0] t);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_tag = t;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check({tag, "_rsp_timeout"}, rsp_valid, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, n;
        rst = 1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0; cmd_tag = 0;
        rsp_ready = 0;
        cmd_valid2 = 0; cmd_write2 = 0; cmd_addr2 = 0; cmd_data2 = 0; cmd_strb2 = 0; cmd_tag2 = 0;
        rsp_ready2 = 0;
        axil2.awready = 1; axil2.wready = 1; axil2.arready = 0;
        axil2.bvalid = 0; axil2.bresp = 0; axil2.buser = 0;
        axil2.rvalid = 0; axil2.rresp = 0; axil2.rdata = 0; axil2.ruser = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", axil.awvalid, 0);
        check("rst_wvalid", axil.wvalid, 0);
        check("rst_arvalid", axil.arvalid, 0);
        check("rst_bready", axil.bready, 0);
        check("rst_rready", axil.rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_data, rsp_resp, rsp_tag, rsp_cycles}, 0);
        check("rst_rsp_cycles2", rsp_cycles2, 0);
        rst = 0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        send_cmd(1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 8'h5A);
        @(negedge clk);
        check("wr_busy_cmd_ready", cmd_ready, 0);
        wait_rsp("wr0");
        check("wr0_awaddr", last_awaddr, 32'h0000_0100);
        check("wr0_awprot", last_awprot, 3'b000);
        check("wr0_wdata", last_wdata, 32'hDEAD_BEEF);
        check("wr0_wstrb", last_wstrb, 4'hF);
        check("wr0_rsp_write", rsp_write, 1);
        check("wr0_rsp_resp", rsp_resp, 2'b00);
        check("wr0_rsp_tag", rsp_tag, 8'h5A);
        check("wr0_rsp_data", rsp_data, 32'h0);
        check("wr0_rsp_cycles", rsp_cycles, 2);
        take_rsp();

        // Read of port count
        rd_val = 32'h0000_0002;
        send_cmd(0, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 8'h11);
        wait_rsp("rd0");
        check("rd0_araddr", last_araddr, 32'h0000_0100);
        check("rd0_arprot", last_arprot, 3'b000);
        check("rd0_rsp_write", rsp_write, 0);
        check("rd0_rsp_data", rsp_data, 32'h2);
        check("rd0_rsp_resp", rsp_resp, 2'b00);
        check("rd0_rsp_tag", rsp_tag, 8'h11);
        check("rd0_rsp_cycles", rsp_cycles, 2);
        take_rsp();

        // Skewed channels: W accepted first, AW after 5 wait cycles
        aw_wait = 5;
        b0 = b_hs;
        send_cmd(1, 32'h0000_0200, 32'h1234_5678, 4'h3, 8'h22);
        @(negedge clk);
        check("skew_c1_awvalid", axil.awvalid, 1);
        check("skew_c1_wvalid", axil.wvalid, 1);
        @(negedge clk);
        check("skew_c2_wvalid", axil.wvalid, 0);
        check("skew_c2_awvalid", axil.awvalid, 1);
        check("skew_c2_awaddr", axil.awaddr, 32'h0000_0200);
        repeat (2) @(negedge clk);
        check("skew_c4_awvalid", axil.awvalid, 1);
        check("skew_c4_awaddr", axil.awaddr, 32'h0000_0200);
        wait_rsp("skew");
        check("skew_b_count", b_hs - b0, 1);
        check("skew_wdata", last_wdata, 32'h1234_5678);
        check("skew_wstrb", last_wstrb, 4'h3);
        check("skew_rsp_cycles", rsp_cycles, 7);
        check("skew_rsp_tag", rsp_tag, 8'h22);
        take_rsp();
        aw_wait = 0;

        // Error read with response backpressure
        r_wait = 3; rresp_val = 2'b10; rd_val = 32'hCAFE_0001;
        send_cmd(0, 32'h0000_0300, 32'h0, 4'h0, 8'h33);
        wait_rsp("err");
        for (int i = 0; i < 4; i++) begin
            check("err_rsp_valid", rsp_valid, 1);
            check("err_rsp_resp", rsp_resp, 2'b10);
            check("err_rsp_data", rsp_data, 32'hCAFE_0001);
            check("err_rsp_tag", rsp_tag, 8'h33);
            check("err_rsp_cycles", rsp_cycles, 5);
            check("err_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        take_rsp();
        check("err_taken_rsp_valid", rsp_valid, 0);
        check("err_taken_cmd_ready", cmd_ready, 1);
        r_wait = 0; rresp_val = 2'b00;

        // Saturation on the CYC_W=4 instance
        @(negedge clk);
        cmd_valid2 = 1; cmd_write2 = 1; cmd_addr2 = 32'h40; cmd_data2 = 32'h55; cmd_strb2 = 4'hF; cmd_tag2 = 8'h44;
        check("sat_cmd_ready", cmd_ready2, 1);
        @(posedge clk); #1;
        cmd_valid2 = 0;
        repeat (20) @(negedge clk);
        axil2.bvalid = 1;
        n = 0;
        while (!rsp_valid2 && n < 50) begin @(negedge clk); n++; end
        check("sat_rsp_timeout", rsp_valid2, 1);
        axil2.bvalid = 0;
        check("sat_rsp_cycles", rsp_cycles2, 4'd15);
        check("sat_rsp_tag", rsp_tag2, 8'h44);
        rsp_ready2 = 1;
        @(negedge clk);
        rsp_ready2 = 0;

        // Reset in the middle of a read
        ar_wait = 10;
        send_cmd(0, 32'h0000_0400, 32'h0, 4'h0, 8'h66);
        @(negedge clk);
        check("mid_arvalid", axil.arvalid, 1);
        rst = 1;
        @(negedge clk);
        check("mid_rst_arvalid", axil.arvalid, 0);
        check("mid_rst_rready", axil.rready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 0;
        ar_wait = 0;
        @(negedge clk);
        check("mid_post_cmd_ready", cmd_ready, 1);
        rd_val = 32'hA5A5_0F0F;
        send_cmd(0, 32'h0000_0104, 32'h0, 4'h0, 8'h77);
        wait_rsp("mid_rd");
        check("mid_rd_data", rsp_data, 32'hA5A5_0F0F);
        check("mid_rd_resp", rsp_resp, 2'b00);
        check("mid_rd_tag", rsp_tag, 8'h77);
        check("mid_rd_cycles", rsp_cycles, 2);
        take_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cndm_proto_axil_cmd_master.md
Name: cndm_proto_axil_cmd_master

Overview:
- Command-driven AXI4-lite master. Converts a simple valid/ready command stream (read or write, address, data, strobe, tag) into single AXI-lite transactions, and returns the result on a valid/ready response stream.
- Drives the per-port/core control register space, e.g. from an embedded config sequencer or a debug bridge.
- It is the initiator counterpart of the register slaves that sit behind the control interconnect.
- One transaction is outstanding at a time. Each response carries a measured bus latency.

Parameters:
- TAG_W, 8, width of command/response tag (min 1).
- CYC_W, 16, width of saturating latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_axil_wr  taxi_axil_if.wr_mst  -  AXI-lite write master; ADDR_W, DATA_W and STRB_W come from this interface
- m_axil_rd  taxi_axil_if.rd_mst  -  AXI-lite read master; same widths as m_axil_wr
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_data  in  DATA_W  write data
- cmd_strb  in  STRB_W  write strobes
- cmd_tag  in  TAG_W  opaque tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_write  out  1  echo of cmd_write
- rsp_data  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  bresp/rresp
- rsp_tag  out  TAG_W  echo of cmd_tag
- rsp_cycles  out  CYC_W  cycles from AR/AW issue to B/R handshake, saturating

Behaviour:
- One clock domain, synchronous active-high reset.
- Reset values:
  - cmd_ready=0 while rst, 1 in the first cycle after reset.
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid = 0.
  - rsp_data/rsp_resp/rsp_tag/rsp_cycles = 0.
- Constant outputs: awprot=arprot=3'b000. All user fields are 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch write/addr/data/strb/tag and clear the cycle counter.
  - Next state is WR_REQ (write) or RD_REQ (read).
  - awvalid/wvalid or arvalid are registered high in the cycle after acceptance (1-cycle issue latency).
- WR_REQ
  - awvalid and wvalid are held independently; each drops the cycle after its own handshake.
  - awaddr/wdata/wstrb are stable while valid.
  - Order of AW vs W acceptance is arbitrary; same-cycle acceptance is legal.
  - When both are done, go to WR_RESP.
- WR_RESP
  - bready=1.
  - On bvalid: capture bresp and go to RSP with rsp_data=0.
- RD_REQ: arvalid held until arready, then go to RD_DATA.
- RD_DATA
  - rready=1.
  - On rvalid: capture rdata/rresp and go to RSP.
- RSP
  - rsp_valid=1, all rsp_* fields stable.
  - On rsp_ready: go to IDLE.
  - cmd_ready is 0 in RSP, so there are no back-to-back command accepts without the response being taken.
- Minimum command-to-command period: 4 cycles when the slave responds with zero wait states.
- bready/rready are asserted only in WR_RESP/RD_DATA. A B/R beat outside those states is a protocol error from the slave and is not consumed.
- rsp_cycles counting:
  - Counter increments every cycle from the first cycle of AW/W/AR assertion up to and including the B/R handshake cycle.
  - It saturates at 2^CYC_W-1 with no wrap.
  - Zero-wait-state slave: write=2, read=2 (the exact value is part of the test plan).
- cmd_* inputs are ignored outside IDLE.
- No timeout: a hung slave holds the FSM in WR_RESP/RD_DATA indefinitely.
- Reset mid-transaction returns to IDLE and drops all valids/readies immediately. The AXI-lite interconnect/slave must be reset in the same cycle.

Decomposition:
- Shared package cndm_proto_pkg holds:
  - AXI resp encoding constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The FSM state enum type.
- No sub-module is needed; the block is a single FSM plus datapath registers, roughly 200 lines.

Test Plan:
- Write, zero-wait slave: cmd write addr=0x0100 data=0xDEADBEEF strb=0xF tag=0x5A.
  - Expect one AW/W with those values and awprot=0.
  - Expect rsp_write=1, rsp_resp=0, rsp_tag=0x5A, rsp_data=0, rsp_cycles=2.
- Read of port count: read addr=0x0100 from a slave returning 0x00000002.
  - Expect rsp_data=0x2, rsp_resp=0.
- Skewed channels: slave holds awready low 5 cycles and accepts W first.
  - Expect wvalid to drop after its handshake, awvalid held and stable, then one B, rsp_cycles=7.
- Error and backpressure: slave returns rresp=2'b10 after 3 wait cycles, and rsp_ready is held low 4 cycles.
  - Expect rsp_resp=2'b10 and rsp_* stable throughout, cmd_ready=0 until the response is taken.
- Saturation: CYC_W=4, slave delays B by 20 cycles.
  - Expect rsp_cycles=15.
- Reset mid-read: assert rst while arvalid=1.
  - Next cycle expect arvalid=0, rready=0, rsp_valid=0.
  - After release, expect cmd_ready=1 and a subsequent read completing normally.
